// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel DDS waveform generator.
// Holds the waveform-mode encoding and the sine quarter-table generator.
package dds_pkg;

    typedef enum logic [1:0] {
        DDS_SQUARE = 2'd0,
        DDS_SAW    = 2'd1,
        DDS_TRI    = 2'd2,
        DDS_SINE   = 2'd3
    } dds_mode_e;

    localparam real DDS_PI = 3.14159265358979323846;

    // Entry idx of the quarter-wave magnitude table.
    // Evaluated with constant arguments only, so it folds to a constant at elaboration.
    function automatic int dds_sine_entry(input int idx, input int phase_w, input int out_w);
        real amp;
        real x;
        amp = real'((1 << (out_w - 1)) - 1);
        x   = DDS_PI / 2.0 * real'(idx) / real'(1 << (phase_w - 2));
        return $rtoi(amp * $sin(x) + 0.5);
    endfunction

endpackage

// File: rtl/dds_multi_wave_if.sv
// Configuration write port of dds_multi_wave: valid/ready handshake carrying
// target channel, frequency word, phase offset and waveform mode.
interface dds_multi_wave_if #(
    parameter int N_CH    = 2,
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic [ACC_W-1:0]   cfg_fword;
    logic [PHASE_W-1:0] cfg_poff;
    logic [1:0]         cfg_mode;

    modport master (
        output cfg_valid, cfg_ch, cfg_fword, cfg_poff, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_fword, cfg_poff, cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/dds_sine_rom.sv
// Combinational quarter-wave sine magnitude lookup.
// addr spans one quadrant; mag is the unsigned amplitude above mid-scale.
module dds_sine_rom #(
    parameter int PHASE_W = 12,
    parameter int OUT_W   = 10
) (
    input  logic [PHASE_W-3:0] addr,
    output logic [OUT_W-2:0]   mag
);
    import dds_pkg::*;

    localparam int DEPTH = 1 << (PHASE_W - 2);
    localparam int MAG_W = OUT_W - 1;

    // NOTE: the table is constant logic, not storage, so it carries no reset.
    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = MAG_W'(dds_sine_entry(i, PHASE_W, OUT_W));
    end

    assign mag = rom[addr];

endmodule

// File: rtl/dds_multi_wave.sv
// Multi-channel DDS: per-channel phase accumulator, phase offset and waveform
// shaper behind a shadow/active register pair retuned on a common commit pulse.
module dds_multi_wave
    import dds_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12,
    parameter int OUT_W   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    dds_multi_wave_if.slave        cfg,
    input  logic                   commit,
    input  logic                   commit_clr,
    output logic [N_CH*OUT_W-1:0]  wave_out,
    output logic [N_CH-1:0]        sq_out,
    output logic                   wave_valid
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [OUT_W-1:0] HALF = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic [ACC_W-1:0]   fword;
        logic [PHASE_W-1:0] poff;
        dds_mode_e          mode;
    } ch_cfg_t;

    ch_cfg_t            shadow_q [N_CH];
    ch_cfg_t            shadow_d [N_CH];
    ch_cfg_t            active_q [N_CH];
    ch_cfg_t            active_d [N_CH];
    logic [ACC_W-1:0]   acc_q    [N_CH];
    logic [ACC_W-1:0]   acc_d    [N_CH];
    logic [PHASE_W-1:0] ph_q     [N_CH];
    logic [PHASE_W-1:0] ph_d     [N_CH];
    dds_mode_e          mode1_q  [N_CH];
    dds_mode_e          mode1_d  [N_CH];
    logic [OUT_W-1:0]   wave_q   [N_CH];
    logic [OUT_W-1:0]   wave_d   [N_CH];
    logic [N_CH-1:0]    msb1_q, msb1_d;
    logic [N_CH-1:0]    sq_q, sq_d;
    logic [2:0]         valid_q, valid_d;
    logic               ready_q, ready_d;

    logic [N_CH-1:0][PHASE_W-3:0] rom_addr;
    logic [N_CH-1:0][OUT_W-2:0]   mag;

    logic wr_en;

    function automatic logic [OUT_W-1:0] shape(
        input logic [PHASE_W-1:0] ph,
        input dds_mode_e          mode,
        input logic [OUT_W-2:0]   m
    );
        logic [PHASE_W-2:0] t;
        logic [OUT_W-1:0]   y;
        t = ph[PHASE_W-1] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0];
        y = '0;
        case (mode)
            DDS_SQUARE: y = {OUT_W{ph[PHASE_W-1]}};
            DDS_SAW:    y = ph[PHASE_W-1 -: OUT_W];
            DDS_TRI:    y = t[PHASE_W-2 -: OUT_W];
            DDS_SINE:   y = ph[PHASE_W-1] ? HALF - {1'b0, m} : HALF + {1'b0, m};
            default:    ;
        endcase
        return y;
    endfunction

    // Ready drops combinationally during commit so a write never races the copy.
    assign cfg.cfg_ready = ready_q & ~commit;
    assign wr_en         = cfg.cfg_valid & cfg.cfg_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign rom_addr[g] = ph_q[g][PHASE_W-2] ? ~ph_q[g][PHASE_W-3:0] : ph_q[g][PHASE_W-3:0];

        dds_sine_rom #(
            .PHASE_W (PHASE_W),
            .OUT_W   (OUT_W)
        ) u_sine_rom (
            .addr (rom_addr[g]),
            .mag  (mag[g])
        );

        assign wave_out[g*OUT_W +: OUT_W] = wave_q[g];
    end

    assign sq_out     = sq_q;
    assign wave_valid = valid_q[2];

    // NOTE: every _d starts from its hold value, so no branch can infer a latch.
    always_comb begin
        ready_d = 1'b1;
        valid_d = {valid_q[1:0], en};
        msb1_d  = msb1_q;
        sq_d    = sq_q;
        for (int c = 0; c < N_CH; c++) begin
            shadow_d[c] = shadow_q[c];
            active_d[c] = active_q[c];
            acc_d[c]    = acc_q[c];
            ph_d[c]     = ph_q[c];
            mode1_d[c]  = mode1_q[c];
            wave_d[c]   = wave_q[c];

            // Out-of-range channel numbers match no entry and are dropped.
            if (wr_en && cfg.cfg_ch == CH_W'(c)) begin
                shadow_d[c] = '{fword: cfg.cfg_fword,
                                poff:  cfg.cfg_poff,
                                mode:  dds_mode_e'(cfg.cfg_mode)};
            end
            if (commit) begin
                active_d[c] = shadow_q[c];
            end

            if (commit && commit_clr) begin
                acc_d[c] = '0;
            end else if (en) begin
                acc_d[c] = acc_q[c] + active_q[c].fword;
            end

            if (en) begin
                ph_d[c]    = acc_q[c][ACC_W-1 -: PHASE_W] + active_q[c].poff;
                mode1_d[c] = active_q[c].mode;
                msb1_d[c]  = acc_q[c][ACC_W-1];
                wave_d[c]  = shape(ph_q[c], mode1_q[c], mag[c]);
                sq_d[c]    = msb1_q[c];
            end
        end
    end

    // NOTE: state updates use non-blocking assignment; blocking is kept to always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            valid_q <= '0;
            msb1_q  <= '0;
            sq_q    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
                acc_q[c]    <= '0;
                ph_q[c]     <= '0;
                mode1_q[c]  <= DDS_SQUARE;
                wave_q[c]   <= '0;
            end
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
            msb1_q  <= msb1_d;
            sq_q    <= sq_d;
            for (int c = 0; c < N_CH; c++) begin
                shadow_q[c] <= shadow_d[c];
                active_q[c] <= active_d[c];
                acc_q[c]    <= acc_d[c];
                ph_q[c]     <= ph_d[c];
                mode1_q[c]  <= mode1_d[c];
                wave_q[c]   <= wave_d[c];
            end
        end
    end

endmodule

// File: tb/tb_dds_multi_wave.sv
// Self-checking bench for dds_multi_wave: directed scenarios plus random traffic,
// compared every cycle against an arithmetic reference model of the generator.
module tb_dds_multi_wave;

    localparam int  N_CH    = 2;
    localparam int  ACC_W   = 32;
    localparam int  PHASE_W = 12;
    localparam int  OUT_W   = 10;
    localparam real PI      = 3.14159265358979323846;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic en         = 1'b0;
    logic commit     = 1'b0;
    logic commit_clr = 1'b0;
    logic [N_CH*OUT_W-1:0] wave_out;
    logic [N_CH-1:0]       sq_out;
    logic                  wave_valid;

    dds_multi_wave_if #(.N_CH(N_CH), .ACC_W(ACC_W), .PHASE_W(PHASE_W)) cfg_if ();

    dds_multi_wave #(
        .N_CH(N_CH), .ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg        (cfg_if),
        .commit     (commit),
        .commit_clr (commit_clr),
        .wave_out   (wave_out),
        .sq_out     (sq_out),
        .wave_valid (wave_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: configuration banks, accumulators, and the
    // samples that are one and two enabled cycles away from the output.
    bit [ACC_W-1:0]   m_acc [N_CH];
    bit [ACC_W-1:0]   sh_fw [N_CH], act_fw [N_CH];
    bit [PHASE_W-1:0] sh_po [N_CH], act_po [N_CH];
    int               sh_md [N_CH], act_md [N_CH];
    int               nxt_w [N_CH], out_w [N_CH];
    bit               nxt_sq[N_CH], out_sq[N_CH];
    bit [2:0]         en_hist;
    bit               m_rdy;

    function automatic int ref_wave(input bit [ACC_W-1:0] acc, input bit [PHASE_W-1:0] poff, input int mode);
        int ph, t, q, a, mag;
        ph = (int'(acc >> (ACC_W - PHASE_W)) + int'(poff)) % (1 << PHASE_W);
        case (mode)
            0: return (ph >= (1 << (PHASE_W - 1))) ? (1 << OUT_W) - 1 : 0;
            1: return ph >> (PHASE_W - OUT_W);
            2: begin
                t = ph % (1 << (PHASE_W - 1));
                if (ph >= (1 << (PHASE_W - 1))) t = (1 << (PHASE_W - 1)) - 1 - t;
                return t >> (PHASE_W - 1 - OUT_W);
            end
            default: begin
                q = ph >> (PHASE_W - 2);
                a = ph % (1 << (PHASE_W - 2));
                if (q % 2 == 1) a = (1 << (PHASE_W - 2)) - 1 - a;
                mag = $rtoi(real'((1 << (OUT_W - 1)) - 1)
                            * $sin(PI / 2.0 * real'(a) / real'(1 << (PHASE_W - 2))) + 0.5);
                return (q < 2) ? (1 << (OUT_W - 1)) + mag : (1 << (OUT_W - 1)) - mag;
            end
        endcase
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_acc[c] = '0; sh_fw[c] = '0; act_fw[c] = '0;
            sh_po[c] = '0; act_po[c] = '0; sh_md[c] = 0; act_md[c] = 0;
            nxt_w[c] = 0; out_w[c] = 0; nxt_sq[c] = 1'b0; out_sq[c] = 1'b0;
        end
        en_hist = '0;
        m_rdy   = 1'b0;
    endfunction

    function automatic void model_edge();
        bit rdy_now;
        int ch;
        rdy_now = m_rdy && !commit;
        en_hist = {en_hist[1:0], en};
        for (int c = 0; c < N_CH; c++) begin
            if (en) begin
                out_w[c]  = nxt_w[c];
                out_sq[c] = nxt_sq[c];
                nxt_w[c]  = ref_wave(m_acc[c], act_po[c], act_md[c]);
                nxt_sq[c] = m_acc[c][ACC_W-1];
            end
            if (commit && commit_clr) m_acc[c] = '0;
            else if (en)              m_acc[c] = m_acc[c] + act_fw[c];
            if (commit) begin
                act_fw[c] = sh_fw[c]; act_po[c] = sh_po[c]; act_md[c] = sh_md[c];
            end
        end
        ch = int'(cfg_if.cfg_ch);
        if (cfg_if.cfg_valid && rdy_now && ch < N_CH) begin
            sh_fw[ch] = cfg_if.cfg_fword;
            sh_po[ch] = cfg_if.cfg_poff;
            sh_md[ch] = int'(cfg_if.cfg_mode);
        end
        m_rdy = 1'b1;
    endfunction

    task automatic compare();
        check("wave_valid", wave_valid, en_hist[2]);
        check("cfg_ready", cfg_if.cfg_ready, m_rdy && !commit);
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("wave_ch%0d", c), wave_out[c*OUT_W +: OUT_W], out_w[c]);
            check($sformatf("sq_ch%0d", c), sq_out[c], out_sq[c]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic write_cfg(input int ch, input bit [ACC_W-1:0] fw, input bit [PHASE_W-1:0] po, input int md);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 1'(ch);
        cfg_if.cfg_fword = fw;
        cfg_if.cfg_poff  = po;
        cfg_if.cfg_mode  = 2'(md);
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic do_commit(input bit clr);
        commit     = 1'b1;
        commit_clr = clr;
        tick();
        commit     = 1'b0;
        commit_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wave"}, wave_out, '0);
        check({tag, "_sq"}, sq_out, '0);
        check({tag, "_valid"}, wave_valid, 1'b0);
        check({tag, "_ready"}, cfg_if.cfg_ready, 1'b0);
    endtask

    function automatic int ch0_sample();
        return int'(wave_out[OUT_W-1:0]);
    endfunction

    int  saw_ref [8];
    int  smp [8];
    int  held;
    bit  peak;

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_fword = '0;
        cfg_if.cfg_poff  = '0;
        cfg_if.cfg_mode  = '0;
        model_reset();

        // Power-up reset and idle.
        repeat (2) @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;
        tick();
        check("ready_after_release", cfg_if.cfg_ready, 1'b1);
        ticks(3);

        // Saw on ch0 at a quarter-turn step.
        write_cfg(0, 32'h4000_0000, '0, 1);
        do_commit(1'b1);
        en = 1'b1;
        ticks(3);
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_ref[i] = ch0_sample();
        end
        for (int i = 0; i < 7; i++)
            check("saw_step", saw_ref[i+1], (saw_ref[i] + 256) % 1024);

        // Square on both channels, ch1 offset by half a turn.
        write_cfg(0, 32'h4000_0000, '0, 0);
        write_cfg(1, 32'h4000_0000, 12'h800, 0);
        do_commit(1'b1);
        ticks(4);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("square_inverse", wave_out[OUT_W +: OUT_W], 1023 - ch0_sample());
        end

        // Sine at a quarter-turn step, then the slowest reverse step.
        write_cfg(0, 32'h4000_0000, '0, 3);
        do_commit(1'b1);
        ticks(3);
        peak = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            smp[i] = ch0_sample();
            if (smp[i] == 1023) peak = 1'b1;
        end
        for (int i = 0; i < 6; i++)
            check("sine_symmetry", smp[i+2], 1024 - smp[i]);
        check("sine_peak_seen", peak, 1'b1);
        write_cfg(0, 32'hFFFF_FFFF, '0, 3);
        do_commit(1'b1);
        ticks(40);
        check("sine_slow_reverse", ch0_sample(), 512);

        // Shadow write without commit leaves the output untouched.
        write_cfg(0, 32'h1234_5678, 12'h3A5, 1);
        held = ch0_sample();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("shadow_only_hold", ch0_sample(), held);
        end

        // Write held across a commit lands one cycle later, takes effect next commit.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 1'b1;
        cfg_if.cfg_fword = 32'h0800_0000;
        cfg_if.cfg_poff  = 12'h100;
        cfg_if.cfg_mode  = 2'd2;
        commit           = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        cfg_if.cfg_valid = 1'b0;
        ticks(10);
        do_commit(1'b0);
        ticks(40);

        // Asynchronous reset mid-run, then replay the saw scenario.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        ticks(4);
        write_cfg(0, 32'h4000_0000, '0, 1);
        do_commit(1'b1);
        en = 1'b1;
        ticks(3);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("saw_after_reset", ch0_sample(), saw_ref[i]);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            en               = ($urandom_range(0, 9) != 0);
            cfg_if.cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_if.cfg_ch    = 1'($urandom_range(0, N_CH - 1));
            cfg_if.cfg_fword = ($urandom_range(0, 1) == 0) ? 32'($urandom) : (32'd1 << $urandom_range(16, 31));
            cfg_if.cfg_poff  = 12'($urandom);
            cfg_if.cfg_mode  = 2'($urandom_range(0, 3));
            commit           = ($urandom_range(0, 11) == 0);
            commit_clr       = 1'($urandom_range(0, 1));
            tick();
        end
        cfg_if.cfg_valid = 1'b0;
        commit           = 1'b0;
        commit_clr       = 1'b0;
        ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
